// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter monitor: FSM state
// encoding, default widths and the terminal count constants.
package updown_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_WRAP_W = 8;

    // Terminal values of the default-width counter.
    localparam logic [DEF_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [DEF_WIDTH-1:0] CNT_MIN = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_ERR   = 2'd2
    } state_t;

endpackage

// File: rtl/updown_count_monitor_sat_counter.sv
// Saturating tally: counts inc pulses, sticks at all-ones, cleared by clr.
module sat_counter
    import updown_pkg::*;
#(
    parameter int unsigned WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [WRAP_W-1:0] value
);

    localparam logic [WRAP_W-1:0] SAT_VAL = '1;

    // Tally register: clear wins, increment only below the ceiling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != SAT_VAL)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/updown_count_monitor.sv
// Monitor for a WIDTH-bit up/down counter: checks every step is +/-1
// modulo 2^WIDTH in the previously selected direction, reports
// terminal-count, wrap and direction-change events, keeps a saturating
// wrap tally and a sticky step error flag.
module updown_count_monitor
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              mode_in,
    input  logic              clr,
    output logic              tc,
    output logic              wrap_pulse,
    output logic              dir_chg,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              step_err
);

    // Width-scaled terminal values (CNT_MAX/CNT_MIN for the default width).
    localparam logic [WIDTH-1:0] TERM_HI = '1;
    localparam logic [WIDTH-1:0] TERM_LO = '0;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] prev_cnt;
    logic             prev_mode;

    logic [WIDTH-1:0] exp_cnt;
    logic             step_ok;
    logic             wrap_hit;
    logic             term_hit;
    logic             mode_flip;

    logic             tc_d;
    logic             wrap_d;
    logic             dir_d;
    logic             err_d;

    // Step prediction and event decode from the previous and current sample.
    always_comb begin
        exp_cnt   = prev_mode ? (prev_cnt - 1'b1) : (prev_cnt + 1'b1);
        step_ok   = (cnt_in == exp_cnt);
        wrap_hit  = (!prev_mode && (prev_cnt == TERM_HI) && (cnt_in == TERM_LO)) ||
                    ( prev_mode && (prev_cnt == TERM_LO) && (cnt_in == TERM_HI));
        term_hit  = (!mode_in && (cnt_in == TERM_HI)) ||
                    ( mode_in && (cnt_in == TERM_LO));
        mode_flip = (mode_in != prev_mode);
    end

    // Next-state and next-output logic; clr overrides every event.
    always_comb begin
        next_state = state;
        tc_d       = 1'b0;
        wrap_d     = 1'b0;
        dir_d      = 1'b0;
        err_d      = step_err;

        case (state)
            S_IDLE: begin
                next_state = S_TRACK;
            end
            S_TRACK: begin
                tc_d  = term_hit;
                dir_d = mode_flip;
                if (step_ok) begin
                    wrap_d = wrap_hit;
                end else begin
                    err_d      = 1'b1;
                    next_state = S_ERR;
                end
            end
            S_ERR: begin
                tc_d  = term_hit;
                dir_d = mode_flip;
                err_d = 1'b1;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        if (clr) begin
            next_state = S_IDLE;
            tc_d       = 1'b0;
            wrap_d     = 1'b0;
            dir_d      = 1'b0;
            err_d      = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Previous-sample registers, loaded unconditionally every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cnt  <= '0;
            prev_mode <= 1'b0;
        end else begin
            prev_cnt  <= cnt_in;
            prev_mode <= mode_in;
        end
    end

    // Registered event and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc         <= 1'b0;
            wrap_pulse <= 1'b0;
            dir_chg    <= 1'b0;
            step_err   <= 1'b0;
        end else begin
            tc         <= tc_d;
            wrap_pulse <= wrap_d;
            dir_chg    <= dir_d;
            step_err   <= err_d;
        end
    end

    // Wrap tally advances on the same edge that raises wrap_pulse.
    sat_counter #(
        .WRAP_W(WRAP_W)
    ) u_wrap_tally (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (wrap_d),
        .value (wrap_cnt)
    );

endmodule
